// File: rtl/aes_pkg.sv
// Shared AES definitions: state geometry, FSM encoding and the S-box math
// used by the SubBytes lanes.
package aes_pkg;

    localparam int AES_STATE_W = 128;
    localparam int AES_BYTES   = 16;

    typedef enum logic [1:0] {IDLE, RUN, DONE} sb_state_e;

    // GF(2^8) multiply modulo the AES polynomial x^8 + x^4 + x^3 + x + 1.
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // Multiplicative inverse as a^254; zero maps to zero as AES requires.
    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] sq;
        logic [7:0] r;
        sq = a;
        r  = 8'h01;
        for (int i = 1; i < 8; i++) begin
            sq = gf_mul(sq, sq);
            r  = gf_mul(r, sq);
        end
        return r;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
        logic [15:0] d;
        d = {x, x} << n;
        return d[15:8];
    endfunction

    function automatic logic [7:0] sbox_fwd(input logic [7:0] x);
        logic [7:0] i;
        i = gf_inv(x);
        return i ^ rotl8(i, 1) ^ rotl8(i, 2) ^ rotl8(i, 3) ^ rotl8(i, 4) ^ 8'h63;
    endfunction

    function automatic logic [7:0] sbox_inv(input logic [7:0] y);
        return gf_inv(rotl8(y, 1) ^ rotl8(y, 3) ^ rotl8(y, 6) ^ 8'h05);
    endfunction

    // Bit offset of byte (beat*lanes + lane) inside the 128-bit state.
    function automatic logic [6:0] byte_bit(input int beat, input int lane, input int lanes);
        return 7'((beat * lanes + lane) * 8);
    endfunction

endpackage

// File: rtl/subbytes_lane.sv
// One S-box lane: forward substitution, plus the inverse path when enabled.
module subbytes_lane
    import aes_pkg::*;
#(
    parameter bit SUPPORT_INV = 1'b1
) (
    input  logic [7:0] data,
    input  logic       inv,
    output logic [7:0] result
);

    if (SUPPORT_INV) begin : g_inv
        assign result = inv ? sbox_inv(data) : sbox_fwd(data);
    end else begin : g_fwd
        logic unused_inv;
        assign unused_inv = inv;
        assign result     = sbox_fwd(data);
    end

endmodule

// File: rtl/subbytes_iter.sv
// Iterative SubBytes/InvSubBytes engine: NUM_LANES bytes of the held state
// are substituted in place per cycle, between two valid/ready handshakes.
module subbytes_iter
    import aes_pkg::*;
#(
    parameter int NUM_LANES   = 4,
    parameter bit SUPPORT_INV = 1'b1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [AES_STATE_W-1:0] in_data,
    input  logic                   in_inv,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [AES_STATE_W-1:0] out_data,
    output logic                   busy
);

    localparam int BEATS = AES_BYTES / NUM_LANES;
    localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BEATS - 1);

    sb_state_e                        state;
    logic [AES_STATE_W-1:0]           data_q;
    logic [AES_STATE_W-1:0]           data_nxt;
    logic [AES_STATE_W-1:0]           lane_sel;
    logic [CNT_W-1:0]                 cnt;
    logic                             inv_q;
    logic [NUM_LANES-1:0][7:0]        lane_in;
    logic [NUM_LANES-1:0][7:0]        lane_out;

    assign lane_sel = data_q >> byte_bit(int'(cnt), 0, NUM_LANES);
    assign lane_in  = lane_sel[NUM_LANES*8-1:0];

    for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
        subbytes_lane #(.SUPPORT_INV(SUPPORT_INV)) u_lane (
            .data   (lane_in[l]),
            .inv    (inv_q),
            .result (lane_out[l])
        );
    end

    // NOTE: data_nxt takes a full default before the indexed writes, so no
    // byte is left unassigned on any path and no latch is inferred.
    always_comb begin
        data_nxt = data_q;
        for (int l = 0; l < NUM_LANES; l++) begin
            data_nxt[byte_bit(int'(cnt), l, NUM_LANES) +: 8] = lane_out[l];
        end
    end

    // Back-to-back accept in DONE depends on out_ready in the same cycle.
    assign in_ready = !rst && ((state == IDLE) || (state == DONE && out_ready));
    assign out_data = data_q;

    // NOTE: all state uses non-blocking assignments so every register sees
    // the pre-edge values of the others. The data register is reset too, so
    // out_data is defined (zero) straight out of reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            data_q    <= '0;
            cnt       <= '0;
            inv_q     <= 1'b0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        data_q <= in_data;
                        inv_q  <= SUPPORT_INV ? in_inv : 1'b0;
                        cnt    <= '0;
                        state  <= RUN;
                        busy   <= 1'b1;
                    end
                end
                RUN: begin
                    data_q <= data_nxt;
                    if (cnt == LAST_CNT) begin
                        cnt       <= '0;
                        state     <= DONE;
                        out_valid <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        if (in_valid) begin
                            data_q <= in_data;
                            inv_q  <= SUPPORT_INV ? in_inv : 1'b0;
                            cnt    <= '0;
                            state  <= RUN;
                        end else begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
